signed_bcd_display_driver: RTL and testbench
============================================

Name: signed_bcd_display_driver

Overview:
Sequential signed-binary to multi-digit 7-segment display driver for the lab ALU result path. It converts a WIDTH-bit two's-complement or unsigned operand to DIGITS decimal digits using an iterative shift-add-3 (double-dabble) engine, one bit per clock. It drives a dedicated sign display plus DIGITS numeral displays, with optional leading-zero blanking and an overflow indication. A start/busy/done handshake lets the ALU FSM launch conversions; the outputs hold the last result until the next conversion completes.

Parameters:
WIDTH, 8, operand width in bits (range 2..16)
DIGITS, 3, number of decimal numeral displays (range 1..5)
SIGNED, 1, 1 = operand is two's complement; 0 = operand is unsigned and the sign display stays blank
BLANK_LZ, 1, 1 = blank leading zero digits; 0 = show all digits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
value  in  WIDTH  operand; sampled on the accepting edge
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when new display data is registered
overflow  out  1  registered; magnitude exceeds 10^DIGITS-1
signHEX  out  7  sign display, active-low, bit6=g..bit0=a
numHEX  out  7*DIGITS  numeral displays; [6:0] = least significant digit, active-low

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, overflow=0; signHEX=7'b1111111; every numHEX digit=7'b1111111 (blank). Reset mid-conversion aborts it and discards partial results.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111.
- States: IDLE, CONVERT, LOAD.
- IDLE: at an edge with start=1 (edge E0), latch the sign (value[WIDTH-1] if SIGNED=1, otherwise 0) and the magnitude, then go to CONVERT. Negative magnitude = (~value)+1, computed in WIDTH bits as unsigned, so -2^(WIDTH-1) gives 2^(WIDTH-1) correctly. The shift counter is cleared.
- CONVERT: edges E1..E_WIDTH perform one double-dabble step each. Before the shift, any BCD nibble >=5 gets +3; then {bcd, magnitude} shifts left by 1. The BCD register is 4*DIGITS+4 bits wide, with the extra nibble for overflow detection. After the WIDTH-th step, go to LOAD.
- LOAD (edge E_WIDTH+1):
  - Register all display outputs; done=1 for exactly one cycle; go to IDLE.
  - overflow=1 when any bit above the low 4*DIGITS BCD bits is set. In that case every numHEX digit shows minus and signHEX is blank.
  - Otherwise signHEX shows minus if sign=1 and the magnitude is nonzero, else blank.
  - With BLANK_LZ=1, zero digits above the most significant nonzero digit are blank. Digit 0 is always shown, so zero displays as "0".
- busy=1 from after E0 through the LOAD edge (WIDTH+1 cycles). Latency from the start edge to the done pulse is WIDTH+1 clocks.
- start while busy (CONVERT or LOAD) is ignored; it is not queued. The earliest next acceptance is the edge after LOAD.
- value changes after E0 have no effect on the conversion in progress.
- Outputs are stable between done pulses; no intermediate values appear.
- numHEX bits above the valid digits do not exist; port width is exactly 7*DIGITS.

Test Plan:
1. Default params; value=8'h80 (-128), start pulse -> done exactly 9 cycles after the start edge; signHEX=0111111; digits (MS..LS)=1111001, 0100100, 0000000; overflow=0.
2. value=8'd5, BLANK_LZ=1 -> signHEX=1111111, digits=1111111, 1111111, 0010010. Repeat with BLANK_LZ=0 -> 1000000, 1000000, 0010010.
3. value=0 -> digits blank, blank, 1000000; signHEX blank. value=8'hFF (-1) -> signHEX=0111111, LS digit=1111001.
4. DIGITS=2, value=8'd127 -> overflow=1, both digits 0111111, signHEX blank. Then value=8'd99 -> overflow=0, digits 0010000, 0010000.
5. Start value=8'd42; re-pulse start with value=8'd7 at cycle 3 -> pulse ignored; done once with digits blank, 0011001, 0100100; busy stays high throughout.
6. Assert reset at cycle 4 of a conversion -> busy=0, done=0, all displays 1111111 immediately (asynchronously). Deassert, start -3 (SIGNED=1) -> signHEX=0111111, LS digit=0110000.

Source files
------------

// File: rtl/signed_bcd_display_driver.sv
// Signed/unsigned binary to DIGITS x 7-segment driver using an iterative double-dabble engine, one bit per clock.
// Latency: done pulses WIDTH+1 clocks after the accepting start edge; display outputs change only on that done edge.
// Backpressure: start is honoured only while idle; a start while busy is dropped, never queued.
module signed_bcd_display_driver #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SIGNED   = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            signHEX,
    output logic [7*DIGITS-1:0]   numHEX
);

    // One spare nibble above the displayed digits catches the first decimal overflow.
    localparam int BW = 4*DIGITS + 4;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic                  nz_q, nz_d;
    logic                  lost_q, lost_d;
    logic [WIDTH-1:0]      mag_q, mag_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [BW-1:0]         bcd_adj;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [6:0]            sign_hex_q, sign_hex_d;
    logic [7*DIGITS-1:0]   num_hex_q, num_hex_d;
    logic                  neg;
    logic                  ovf_now;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Walk from the top digit down; zeros stay blank until the first nonzero digit. Digit 0 always shows.
    function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] bcd);
        logic [7*DIGITS-1:0] r;
        logic                lead;
        logic [3:0]          nib;
        r    = '1;
        lead = 1'b1;
        for (int i = DIGITS-1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if ((BLANK_LZ != 0) && lead && (nib == 4'd0) && (i != 0)) begin
                r[7*i +: 7] = SEG_BLANK;
            end else begin
                r[7*i +: 7] = seg7(nib);
                lead        = 1'b0;
            end
        end
        return r;
    endfunction

    // Next-state logic: operand capture, one shift-add-3 step per cycle, then display load.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        nz_d       = nz_q;
        lost_d     = lost_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        sign_hex_d = sign_hex_q;
        num_hex_d  = num_hex_q;
        neg        = (SIGNED != 0) && value[WIDTH-1];
        ovf_now    = lost_q || (|bcd_q[BW-1:4*DIGITS]);

        // Add 3 to every nibble >= 5 so the following shift carries correctly into the next decade.
        bcd_adj = bcd_q;
        for (int i = 0; i <= DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = neg;
                    // Two's-complement negate in WIDTH bits; the most negative value maps to 2^(WIDTH-1).
                    mag_d   = neg ? (~value + WIDTH'(1)) : value;
                    nz_d    = |value;
                    bcd_d   = '0;
                    lost_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d  = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d  = {mag_q[WIDTH-2:0], 1'b0};
                // Any bit pushed out of the spare nibble means the value is far beyond the display range.
                lost_d = lost_q | bcd_adj[BW-1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ovf_d  = ovf_now;
                done_d = 1'b1;
                if (ovf_now) begin
                    sign_hex_d = SEG_BLANK;
                    num_hex_d  = {DIGITS{SEG_MINUS}};
                end else begin
                    sign_hex_d = (sign_q && nz_q) ? SEG_MINUS : SEG_BLANK;
                    num_hex_d  = render(bcd_q[4*DIGITS-1:0]);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion and blanks the displays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            nz_q       <= 1'b0;
            lost_q     <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sign_hex_q <= SEG_BLANK;
            num_hex_q  <= '1;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            nz_q       <= nz_d;
            lost_q     <= lost_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            sign_hex_q <= sign_hex_d;
            num_hex_q  <= num_hex_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign signHEX  = sign_hex_q;
    assign numHEX   = num_hex_q;

endmodule

// File: tb/tb_signed_bcd_display_driver.sv
// Bench for signed_bcd_display_driver: four parameter variants share one stimulus stream.
// Each conversion is compared with an arithmetic decimal model; latency, pulse width and hold are checked too.
// Reset, ignored restart, and asynchronous reset mid-conversion are exercised explicitly.
module tb_signed_bcd_display_driver;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam int PD [4] = '{3, 2, 3, 3};
    localparam int PS [4] = '{1, 1, 1, 0};
    localparam int PB [4] = '{1, 1, 0, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] value;

    wire [3:0]       b;
    wire [3:0]       dn;
    wire [3:0]       ov;
    wire [3:0][6:0]  sh;
    wire [20:0]      n0;
    wire [13:0]      n1;
    wire [20:0]      n2;
    wire [20:0]      n3;

    int total = 0;
    int bad   = 0;

    logic [6:0]  es [4];
    logic [34:0] en [4];
    logic        eo [4];

    always #5 clk = ~clk;

    signed_bcd_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .value(value), .busy(b[0]), .done(dn[0]),
        .overflow(ov[0]), .signHEX(sh[0]), .numHEX(n0));
    signed_bcd_display_driver #(.WIDTH(8), .DIGITS(2), .SIGNED(1), .BLANK_LZ(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .value(value), .busy(b[1]), .done(dn[1]),
        .overflow(ov[1]), .signHEX(sh[1]), .numHEX(n1));
    signed_bcd_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(0)) u2 (
        .clk(clk), .reset(reset), .start(start), .value(value), .busy(b[2]), .done(dn[2]),
        .overflow(ov[2]), .signHEX(sh[2]), .numHEX(n2));
    signed_bcd_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)) u3 (
        .clk(clk), .reset(reset), .start(start), .value(value), .busy(b[3]), .done(dn[3]),
        .overflow(ov[3]), .signHEX(sh[3]), .numHEX(n3));

    function automatic logic [34:0] nget(input int i);
        case (i)
            0:       return 35'(n0);
            1:       return 35'(n1);
            2:       return 35'(n2);
            default: return 35'(n3);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Decimal reference: absolute value, range test, then base-10 digit extraction.
    function automatic void model(input logic [7:0] v, input int d, input int sg, input int blz,
                                  output logic [6:0] s, output logic [34:0] n, output logic o);
        int mag, lim, t, msd;
        int dg [5];
        bit neg;
        neg = (sg != 0) && v[7];
        mag = neg ? 256 - int'(v) : int'(v);
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        lim = lim - 1;
        o = (mag > lim);
        n = '0;
        if (o) begin
            s = BLANK;
            for (int i = 0; i < d; i++) n[7*i +: 7] = MINUS;
        end else begin
            s = (neg && mag != 0) ? MINUS : BLANK;
            t = mag;
            msd = 0;
            for (int i = 0; i < d; i++) begin
                dg[i] = t % 10;
                t = t / 10;
                if (dg[i] != 0) msd = i;
            end
            for (int i = 0; i < d; i++)
                n[7*i +: 7] = ((blz != 0) && (i > msd)) ? BLANK : SEG[dg[i]];
        end
    endfunction

    task automatic set_reset_exp();
        for (int i = 0; i < 4; i++) begin
            es[i] = BLANK;
            en[i] = (35'h1 << (7*PD[i])) - 35'h1;
            eo[i] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_sign%0d", tag, i), 64'(sh[i]), 64'(es[i]));
            chk($sformatf("%s_num%0d", tag, i), 64'(nget(i)), 64'(en[i]));
            chk($sformatf("%s_ovf%0d", tag, i), 64'(ov[i]), 64'(eo[i]));
        end
    endtask

    // One conversion; optionally re-pulses start mid-conversion with another operand.
    task automatic do_conv(input logic [7:0] v, input bit restart);
        logic [6:0]  ns [4];
        logic [34:0] nn [4];
        logic        no [4];
        int ndone, dk;
        for (int i = 0; i < 4; i++) model(v, PD[i], PS[i], PB[i], ns[i], nn[i], no[i]);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 8'($urandom);
        ndone = 0;
        dk = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 4 && restart) start = 1'b0;
            if (dn[0]) begin
                ndone++;
                if (dk == 0) dk = k;
            end
            if (k < 9) begin
                chk($sformatf("busy_k%0d_v%h", k, v), 64'(b), 64'hF);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("hold_num%0d_k%0d", i, k), 64'(nget(i)), 64'(en[i]));
                    chk($sformatf("hold_sign%0d_k%0d", i, k), 64'(sh[i]), 64'(es[i]));
                end
            end
            if (k == 9) begin
                for (int i = 0; i < 4; i++) begin
                    es[i] = ns[i];
                    en[i] = nn[i];
                    eo[i] = no[i];
                end
                chk($sformatf("done_v%h", v), 64'(dn), 64'hF);
                chk($sformatf("idle_v%h", v), 64'(b), 64'h0);
                check_outputs($sformatf("res_v%h", v));
            end
            if (k == 10) chk($sformatf("donepulse_v%h", v), 64'(dn), 64'h0);
            if (k == 3 && restart) begin
                start = 1'b1;
                value = 8'd7;
            end
        end
        chk($sformatf("latency_v%h", v), 64'(dk), 64'd9);
        chk($sformatf("ndone_v%h", v), 64'(ndone), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = 8'h00;
        set_reset_exp();
        #12;
        check_outputs("reset");
        chk("reset_busy", 64'(b), 64'h0);
        chk("reset_done", 64'(dn), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        do_conv(8'h80, 1'b0);
        do_conv(8'h05, 1'b0);
        do_conv(8'h00, 1'b0);
        do_conv(8'hFF, 1'b0);
        do_conv(8'h7F, 1'b0);
        do_conv(8'h63, 1'b0);
        do_conv(8'h2A, 1'b1);

        // Asynchronous reset four cycles into a conversion.
        @(negedge clk);
        value = 8'h9C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        set_reset_exp();
        check_outputs("midreset");
        chk("midreset_busy", 64'(b), 64'h0);
        chk("midreset_done", 64'(dn), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        do_conv(8'hFD, 1'b0);
        for (int r = 0; r < 40; r++) do_conv(8'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always reaches a verdict.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
